// File: rtl/ula_seq.sv
// Registered signed ALU: single-cycle logic/add/sub/slt, WIDTH-cycle shift-add multiply.
// Optional build macro ULA_SAT_EN makes ADD, SUB and MUL saturate on overflow.
module ula_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic        [2:0]       F,
  output logic signed [WIDTH-1:0] Saida,
  output logic                    FLAG_O,
  output logic                    FLAG_Z,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef ULA_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_saida, w_saida_nxt;
  logic             r_flag_o, w_flag_o_nxt;
  logic             r_flag_z, w_flag_z_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [PW-1:0]    r_acc, w_acc_nxt;
  logic [PW-1:0]    r_mcand, w_mcand_nxt;
  logic [WIDTH-1:0] r_mplier, w_mplier_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_neg, w_neg_nxt;

  logic [WIDTH-1:0] w_sum, w_diff, w_alu_res, w_a_mag, w_b_mag, w_mul_res;
  logic             w_add_ovf, w_sub_ovf, w_alu_ovf, w_slt, w_mul_ovf;
  logic [PW-1:0]    w_step, w_prod;

  // Single-cycle datapath
  assign w_sum     = A + B;
  assign w_diff    = A - B;
  assign w_slt     = (A < B);
  assign w_add_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_sum[WIDTH-1] != A[WIDTH-1]);
  assign w_sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_diff[WIDTH-1] != A[WIDTH-1]);
  assign w_a_mag   = A[WIDTH-1] ? (~A + 1'b1) : A;
  assign w_b_mag   = B[WIDTH-1] ? (~B + 1'b1) : B;

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    case (F)
      OP_AND: w_alu_res = A & B;
      OP_OR:  w_alu_res = A | B;
      OP_XOR: w_alu_res = A ^ B;
      OP_ADD: begin
        w_alu_ovf = w_add_ovf;
        w_alu_res = (SAT_EN && w_add_ovf) ? (A[WIDTH-1] ? SMIN : SMAX) : w_sum;
      end
      OP_SUB: begin
        w_alu_ovf = w_sub_ovf;
        w_alu_res = (SAT_EN && w_sub_ovf) ? (A[WIDTH-1] ? SMIN : SMAX) : w_diff;
      end
      OP_SLT:  w_alu_res = WIDTH'(w_slt);
      default: w_alu_res = '0;
    endcase
  end

  // Multiply step; the magnitude of the most negative value fits unsigned in WIDTH bits
  assign w_step    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod    = r_neg ? (~w_step + 1'b1) : w_step;
  assign w_mul_ovf = (w_prod != {{WIDTH{w_prod[WIDTH-1]}}, w_prod[WIDTH-1:0]});
  assign w_mul_res = (SAT_EN && w_mul_ovf) ? (r_neg ? SMIN : SMAX) : w_prod[WIDTH-1:0];

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_saida_nxt  = r_saida;
    w_flag_o_nxt = r_flag_o;
    w_flag_z_nxt = r_flag_z;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_acc_nxt    = r_acc;
    w_mcand_nxt  = r_mcand;
    w_mplier_nxt = r_mplier;
    w_cnt_nxt    = r_cnt;
    w_neg_nxt    = r_neg;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (F == OP_MUL) begin
            w_state_nxt  = ST_MUL;
            w_busy_nxt   = 1'b1;
            w_acc_nxt    = '0;
            w_mcand_nxt  = {{WIDTH{1'b0}}, w_a_mag};
            w_mplier_nxt = w_b_mag;
            w_cnt_nxt    = '0;
            w_neg_nxt    = A[WIDTH-1] ^ B[WIDTH-1];
          end else begin
            w_saida_nxt  = w_alu_res;
            w_flag_o_nxt = w_alu_ovf;
            w_flag_z_nxt = (w_alu_res == '0);
            w_done_nxt   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        w_acc_nxt    = w_step;
        w_mcand_nxt  = r_mcand << 1;
        w_mplier_nxt = r_mplier >> 1;
        w_cnt_nxt    = r_cnt + 1'b1;
        if (r_cnt == CW'(WIDTH - 1)) begin
          w_state_nxt  = ST_IDLE;
          w_busy_nxt   = 1'b0;
          w_saida_nxt  = w_mul_res;
          w_flag_o_nxt = w_mul_ovf;
          w_flag_z_nxt = (w_mul_res == '0);
          w_done_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_saida  <= '0;
      r_flag_o <= 1'b0;
      r_flag_z <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_saida  <= w_saida_nxt;
      r_flag_o <= w_flag_o_nxt;
      r_flag_z <= w_flag_z_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_acc    <= w_acc_nxt;
      r_mcand  <= w_mcand_nxt;
      r_mplier <= w_mplier_nxt;
      r_cnt    <= w_cnt_nxt;
      r_neg    <= w_neg_nxt;
    end
  end

  assign Saida  = r_saida;
  assign FLAG_O = r_flag_o;
  assign FLAG_Z = r_flag_z;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq at WIDTH=8 and WIDTH=16; expectations follow ULA_SAT_EN.
module tb_ula_seq;

`ifdef ULA_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start16;
  logic signed [7:0]  A, B, Saida;
  logic signed [15:0] A16, B16, Saida16;
  logic [2:0] F, F16;
  logic FLAG_O, FLAG_Z, busy, done;
  logic FLAG_O16, FLAG_Z16, busy16, done16;

  int checks = 0;
  int errors = 0;
  int extra, busy_n, ndone, done_at;

  always #5 clk = ~clk;

  ula_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .F(F),
    .Saida(Saida), .FLAG_O(FLAG_O), .FLAG_Z(FLAG_Z), .busy(busy), .done(done)
  );

  ula_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .A(A16), .B(B16), .F(F16),
    .Saida(Saida16), .FLAG_O(FLAG_O16), .FLAG_Z(FLAG_Z16), .busy(busy16), .done(done16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 8-bit unit and wait (bounded) for its done pulse
  task automatic run_op(input int a, input int b, input logic [2:0] f);
    @(negedge clk);
    A = 8'(a); B = 8'(b); F = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; extra = 0; busy_n = 0;
    while (!done && extra < 40) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
      extra++;
    end
  endtask

  task automatic run16(input int a, input int b, input logic [2:0] f);
    @(negedge clk);
    A16 = 16'(a); B16 = 16'(b); F16 = f; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; extra = 0; busy_n = 0;
    while (!done16 && extra < 60) begin
      if (busy16) busy_n++;
      @(posedge clk); #1;
      extra++;
    end
  endtask

  task automatic expect8(input string tag, input int s, input logic o, input logic z);
    check({tag, "_saida"}, Saida, s);
    check({tag, "_flag_o"}, FLAG_O, o);
    check({tag, "_flag_z"}, FLAG_Z, z);
    check({tag, "_done"}, done, 1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start16 = 1'b0;
    A = '0; B = '0; F = '0; A16 = '0; B16 = '0; F16 = '0;
    #12;
    check("rst_saida", Saida, 0);
    check("rst_flags", {FLAG_O, FLAG_Z, busy, done}, 0);
    check("rst16_outs", {Saida16, FLAG_O16, FLAG_Z16, busy16, done16}, 0);
    @(negedge clk); rst_n = 1'b1;

    run_op(127, 1, OP_ADD);
    expect8("add_ovf", SAT ? 127 : -128, 1'b1, 1'b0);
    check("add_ovf_lat", extra, 0);
    check("add_ovf_nobusy", busy_n, 0);
    @(posedge clk); #1;
    check("add_done_pulse", done, 0);
    check("add_hold", Saida, SAT ? 127 : -128);

    run_op(-128, 1, OP_SUB);
    expect8("sub_ovf", SAT ? -128 : 127, 1'b1, 1'b0);
    run_op(5, 7, OP_SUB);
    expect8("sub_neg", -2, 1'b0, 1'b0);

    run_op(-12, 10, OP_MUL);
    expect8("mul_m12x10", -120, 1'b0, 1'b0);
    check("mul_lat", extra, 8);
    check("mul_busy_cycles", busy_n, 8);
    check("mul_busy_clr", busy, 0);
    @(posedge clk); #1;
    check("mul_done_pulse", done, 0);

    run_op(16, 8, OP_MUL);
    expect8("mul_16x8", SAT ? 127 : -128, 1'b1, 1'b0);
    run_op(-128, -1, OP_MUL);
    expect8("mul_min_x_m1", SAT ? 127 : -128, 1'b1, 1'b0);
    run_op(-128, 1, OP_MUL);
    expect8("mul_min_x_1", -128, 1'b0, 1'b0);
    run_op(0, -5, OP_MUL);
    expect8("mul_zero", 0, 1'b0, 1'b1);

    // Inputs and start toggled mid-multiply must not disturb it
    @(negedge clk);
    A = 8'(-12); B = 8'(10); F = OP_MUL; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ndone = 0; done_at = -1;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) begin A = 8'(1); B = 8'(1); F = OP_ADD; start = 1'b1; end
      if (k == 4) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin ndone++; done_at = k; end
    end
    check("mid_ndone", ndone, 1);
    check("mid_done_at", done_at, 8);
    check("mid_saida", Saida, -120);

    // Start presented in the MUL done cycle is accepted
    run_op(3, 5, OP_MUL);
    expect8("mul_3x5", 15, 1'b0, 1'b0);
    A = 8'(2); B = 8'(2); F = OP_ADD; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    expect8("donecyc_add", 4, 1'b0, 1'b0);

    // Back-to-back single-cycle ops keep done high
    @(negedge clk);
    A = 8'(1); B = 8'(2); F = OP_ADD; start = 1'b1;
    @(posedge clk); #1;
    expect8("b2b_1", 3, 1'b0, 1'b0);
    A = 8'(4); B = 8'(4); F = OP_XOR;
    @(posedge clk); #1;
    start = 1'b0;
    expect8("b2b_2", 0, 1'b0, 1'b1);

    run_op(8'h0F, 8'hF0, OP_AND);
    expect8("and_zero", 0, 1'b0, 1'b1);
    run_op(8'h0F, 8'hF0, OP_OR);
    expect8("or", -1, 1'b0, 1'b0);
    run_op(8'h55, 8'h0F, OP_XOR);
    expect8("xor", 90, 1'b0, 1'b0);
    run_op(-1, 1, OP_SLT);
    expect8("slt_true", 1, 1'b0, 1'b0);
    run_op(1, -1, OP_SLT);
    expect8("slt_false", 0, 1'b0, 1'b1);
    run_op(127, 1, OP_ADD);
    run_op(5, 3, OP_RSV);
    expect8("reserved", 0, 1'b0, 1'b1);

    // Reset four cycles into a multiply
    @(negedge clk);
    A = 8'(7); B = 8'(9); F = OP_MUL; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_saida", Saida, 0);
    check("midrst_flags", {FLAG_O, FLAG_Z, busy, done}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    run_op(3, 4, OP_ADD);
    expect8("post_rst_add", 7, 1'b0, 1'b0);
    check("post_rst_lat", extra, 0);

    // WIDTH=16 unit
    run16(32767, 1, OP_ADD);
    check("w16_add_saida", Saida16, SAT ? 32767 : -32768);
    check("w16_add_flag_o", FLAG_O16, 1);
    check("w16_add_lat", extra, 0);
    run16(200, -3, OP_MUL);
    check("w16_mul_saida", Saida16, -600);
    check("w16_mul_flag_o", FLAG_O16, 0);
    check("w16_mul_lat", extra, 16);
    check("w16_mul_busy", busy_n, 16);
    run16(256, 128, OP_MUL);
    check("w16_mul_ovf_saida", Saida16, SAT ? 32767 : -32768);
    check("w16_mul_ovf_flag", FLAG_O16, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
